// File: rtl/common_pkg.sv
// rtl/common_pkg.sv - shared cbus request/response types, size/length encodings and arbiter state
package common;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2
    } msize_t;

    // Burst length is encoded as beats-1.
    localparam logic [7:0] MLEN1  = 8'd0;
    localparam logic [7:0] MLEN2  = 8'd1;
    localparam logic [7:0] MLEN4  = 8'd3;
    localparam logic [7:0] MLEN8  = 8'd7;
    localparam logic [7:0] MLEN16 = 8'd15;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [31:0] addr;
        msize_t      size;
        logic [7:0]  len;
        logic [31:0] data;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/cbus_arbiter.sv
// rtl/cbus_arbiter.sv - round-robin arbiter sharing one cache bus among NUM_REQ cache requesters
module cbus_arbiter
    import common::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int IDX_BITS = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                reset,
    input  cbus_req_t           ireqs [NUM_REQ],
    output cbus_resp_t          oresps [NUM_REQ],
    output cbus_req_t           oreq,
    input  cbus_resp_t          iresp,
    output logic                busy,
    output logic [IDX_BITS-1:0] grant_idx,
    output logic                len_err
);

    arb_state_t          state, state_next;
    logic [IDX_BITS-1:0] grant_next;
    logic [IDX_BITS-1:0] rr_ptr, rr_next;
    logic [7:0]          beat_cnt, beat_next;
    logic                len_err_next;
    logic [NUM_REQ-1:0]  valids;
    logic                pick_found;
    logic [IDX_BITS-1:0] pick_idx;

    // Explicit compare-and-wrap so non-power-of-2 port counts wrap correctly.
    function automatic logic [IDX_BITS-1:0] next_idx(input logic [IDX_BITS-1:0] i);
        return (i == IDX_BITS'(NUM_REQ - 1)) ? '0 : i + IDX_BITS'(1);
    endfunction

    function automatic logic [IDX_BITS:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                                  input logic [IDX_BITS-1:0] ptr);
        logic                found;
        logic [IDX_BITS-1:0] win;
        logic [IDX_BITS-1:0] idx;
        found = 1'b0;
        win   = ptr;
        idx   = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && v[idx]) begin
                found = 1'b1;
                win   = idx;
            end
            idx = next_idx(idx);
        end
        return {found, win};
    endfunction

    always_comb begin
        valids = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            valids[k] = ireqs[k].valid;
        end
    end

    assign {pick_found, pick_idx} = rr_pick(valids, rr_ptr);
    assign busy = (state == BUSY);

    always_comb begin
        state_next   = state;
        grant_next   = grant_idx;
        rr_next      = rr_ptr;
        beat_next    = beat_cnt;
        len_err_next = len_err;
        oreq         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            oresps[k] = '0;
        end

        case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_next = pick_idx;
                    beat_next  = 8'd0;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                oreq              = ireqs[grant_idx];
                oresps[grant_idx] = iresp;
                if (iresp.ready) begin
                    beat_next = beat_cnt + 8'd1;
                    if (iresp.last) begin
                        if (beat_cnt != oreq.len) begin
                            len_err_next = 1'b1;
                        end
                        state_next = IDLE;
                        rr_next    = next_idx(grant_idx);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant_idx <= '0;
            rr_ptr    <= '0;
            beat_cnt  <= 8'd0;
            len_err   <= 1'b0;
        end else begin
            state     <= state_next;
            grant_idx <= grant_next;
            rr_ptr    <= rr_next;
            beat_cnt  <= beat_next;
            len_err   <= len_err_next;
        end
    end

    // The grantee must hold valid for the whole burst.
    grantee_holds_valid: assert property (@(posedge clk) disable iff (reset)
        (state == BUSY) |-> oreq.valid);

endmodule
